// File: rtl/bus_pkg.sv
// Shared bus constants, STATUS layout and UART FSM state type for the peripheral window.
package bus_pkg;

  localparam logic [31:0] UART_BASE  = 32'h8000_0000;
  localparam logic [2:0]  OFF_TXDATA = 3'd0;
  localparam logic [2:0]  OFF_STATUS = 3'd4;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BAUD_W    = 16;
  localparam int unsigned BIT_IDX_W = 3;
  localparam int unsigned FIFO_AW   = 2;
  localparam int unsigned FIFO_CW   = 3;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// 4x8 circular transmit buffer; pushes while full and pops while empty are ignored.
module uart_tx_fifo
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [BYTE_W-1:0]   din,
  output logic [BYTE_W-1:0]   dout,
  output logic [FIFO_CW-1:0]  count,
  output logic                full,
  output logic                empty
);

  logic [BYTE_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CW-1:0] count_q, count_d;
  logic               push_ok, pop_ok;

  assign full    = (count_q == FIFO_CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally at the 2-bit boundary
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + FIFO_CW'(1);
      2'b01:   count_d = count_q - FIFO_CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, status/ack registers, overflow flag and serialiser FSM.
module mmio_uart_tx
  import bus_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ack,
  output logic              tx
);

  uart_state_t          state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 ack_q, ack_d;
  logic [DATA_W-1:0]    read_data_q, read_data_d;
  logic                 ovf_q, ovf_d;

  logic                 acc, wr_acc, rd_acc, is_status, baud_last;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BYTE_W-1:0]    fifo_dout;
  logic [FIFO_CW-1:0]   fifo_count;
  logic [DATA_W-1:0]    status_c;
  logic                 unused_bits;

  assign unused_bits = ^{address[1:0], write_data[DATA_W-1:BYTE_W]};

  assign is_status = (address[2] == OFF_STATUS[2]);
  assign acc       = en && (read || write);
  assign wr_acc    = en && write;
  assign rd_acc    = en && read && !write;
  assign fifo_push = wr_acc && !is_status;
  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign idx_nxt   = idx_q + BIT_IDX_W'(1);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (write_data[BYTE_W-1:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // STATUS view of the pre-edge state
  always_comb begin
    status_c                                 = '0;
    status_c[ST_FULL]                        = fifo_full;
    status_c[ST_EMPTY]                       = fifo_empty;
    status_c[ST_BUSY]                        = (state_q != IDLE);
    status_c[ST_OVF]                         = ovf_q;
    status_c[ST_CNT_LSB +: FIFO_CW]          = fifo_count;
  end

  // Bus response and sticky overflow; a dropped push sets it, a STATUS write of bit 3 clears it
  always_comb begin
    ack_d       = acc;
    read_data_d = '0;
    ovf_d       = ovf_q;
    if (rd_acc && is_status) read_data_d = status_c;
    if (fifo_push && fifo_full) ovf_d = 1'b1;
    else if (wr_acc && is_status && write_data[ST_OVF]) ovf_d = 1'b0;
  end

  // Serialiser next state; tx is registered from the next-state values so it lines up with the state
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == BIT_IDX_W'(7)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_nxt;
            tx_d  = shift_q[idx_nxt];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      ack_q       <= 1'b0;
      read_data_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ack_q       <= ack_d;
      read_data_q <= read_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign tx        = tx_q;
  assign ack       = ack_q;
  assign read_data = read_data_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus accesses with per-access checks, plus a serial-line monitor scored against a byte queue.
module tb_mmio_uart_tx;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, read, write;
  logic [2:0]  address;
  logic [31:0] write_data, read_data;
  logic        ack, tx;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];
  bit          mon_busy = 1'b0;

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .address    (address),
    .read       (read),
    .write      (write),
    .write_data (write_data),
    .read_data  (read_data),
    .ack        (ack),
    .tx         (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one bus cycle at a negedge, then check the response at the following negedge
  task automatic drive(input logic e, input logic r, input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic exp_ack, input logic [31:0] exp_rd,
                       input string tag);
    en = e; read = r; write = w; address = a; write_data = d;
    @(negedge clk);
    check_val({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    check_val({tag, "_rdata"}, read_data, exp_rd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input string tag);
    drive(1'b1, 1'b0, 1'b1, a, d, 1'b1, 32'h0, tag);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    drive(1'b1, 1'b1, 1'b0, a, 32'h0, 1'b1, exp, tag);
  endtask

  task automatic idle_bus();
    en = 1'b0; read = 1'b0; write = 1'b0; address = 3'd0; write_data = 32'h0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy) done = 1'b1;
    end
    check_val({tag, "_drain"}, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Line monitor: mid-bit sampling of each frame, byte scored against the expected queue
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin : frame
        logic [9:0]  bits;
        bit          aborted;
        int unsigned t0;
        mon_busy = 1'b1;
        t0 = cyc;
        aborted = 1'b0;
        repeat (2) @(negedge clk);
        if (reset) aborted = 1'b1;
        bits[0] = tx;
        for (int k = 1; k < 10; k++) begin
          repeat (CPB) @(negedge clk);
          if (reset) aborted = 1'b1;
          bits[k] = tx;
        end
        @(negedge clk);
        if (reset) aborted = 1'b1;
        if (!aborted) begin
          start_q.push_back(t0);
          check_val("start_bit", 32'(bits[0]), 32'd0);
          check_val("stop_bit", 32'(bits[9]), 32'd1);
          if (exp_q.size() == 0) check_val("unexpected_frame", 32'(bits[8:1]), 32'h100);
          else check_val("frame_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_bus();
    repeat (3) @(negedge clk);
    check_val("reset_tx", 32'(tx), 32'd1);
    check_val("reset_ack", 32'(ack), 32'd0);
    check_val("reset_rdata", read_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    rd(3'd4, 32'h2, "reset_status");
    idle_bus();
    @(negedge clk);

    // Single byte, start bit follows one edge after the push
    exp_q.push_back(8'hA5);
    wr(3'd0, 32'hA5, "single_wr");
    idle_bus();
    check_val("single_tx_hold", 32'(tx), 32'd1);
    @(negedge clk);
    check_val("single_tx_fall", 32'(tx), 32'd0);
    wait_drain("single");
    rd(3'd4, 32'h2, "single_status");
    idle_bus();
    @(negedge clk);

    // Back-to-back frames must be contiguous
    start_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    wr(3'd0, 32'h01, "b2b_wr0");
    wr(3'd0, 32'h02, "b2b_wr1");
    wr(3'd0, 32'h03, "b2b_wr2");
    rd(3'd4, 32'h24, "b2b_status");
    idle_bus();
    wait_drain("b2b");
    check_val("b2b_frames", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check_val("b2b_gap01", start_q[1] - start_q[0], 32'(10 * CPB));
      check_val("b2b_gap12", start_q[2] - start_q[1], 32'(10 * CPB));
    end

    // Overflow: first byte is popped right away, four fill the FIFO, the sixth is dropped
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < 6; i++) wr(3'd0, 32'(8'h10 + i), $sformatf("ovf_wr%0d", i));
    rd(3'd4, 32'h4D, "ovf_status_set");
    wr(3'd4, 32'h8, "ovf_clear");
    rd(3'd4, 32'h45, "ovf_status_clr");
    idle_bus();
    wait_drain("ovf");
    rd(3'd4, 32'h2, "ovf_status_end");

    // Decode and strobes
    drive(1'b0, 1'b0, 1'b1, 3'd0, 32'h77, 1'b0, 32'h0, "noen_wr");
    drive(1'b0, 1'b1, 1'b0, 3'd4, 32'h0, 1'b0, 32'h0, "noen_rd");
    idle_bus();
    repeat (3) @(negedge clk);
    check_val("noen_tx", 32'(tx), 32'd1);
    rd(3'd4, 32'h2, "noen_status");
    exp_q.push_back(8'h3C);
    drive(1'b1, 1'b1, 1'b1, 3'd0, 32'h3C, 1'b1, 32'h0, "rw_both");
    rd(3'd6, 32'h10, "status_alias");
    rd(3'd2, 32'h0, "txdata_read");
    idle_bus();
    wait_drain("decode");
    rd(3'd4, 32'h2, "decode_status");

    // Reset mid-frame discards the frame and the queued bytes
    wr(3'd0, 32'h5A, "rst_wr0");
    wr(3'd0, 32'h11, "rst_wr1");
    wr(3'd0, 32'h22, "rst_wr2");
    idle_bus();
    repeat (8) @(negedge clk);
    rd(3'd4, 32'h24, "rst_pre_status");
    wr(3'd4, 32'h0, "rst_pre_ack");
    idle_bus();
    start_q.delete();
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_tx_async", 32'(tx), 32'd1);
    check_val("rst_ack_async", 32'(ack), 32'd0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd(3'd4, 32'h2, "rst_status");
    idle_bus();
    repeat (60) @(negedge clk);
    check_val("rst_tx_idle", 32'(tx), 32'd1);
    check_val("rst_no_frames", 32'(start_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
